imem_boot_ctrl: RTL
===================

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the word-address width of the instruction memory.
REQ-002 Parameter DEPTH, default 256, SHALL set the number of 32-bit words that may be loaded (DEPTH = 2**ADDR_W).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 ld_valid  input  1  SHALL indicate that a loader byte is present on ld_data.
REQ-006 ld_data  input  8  SHALL carry the program byte, most-significant byte of each word first.
REQ-007 ld_last  input  1  SHALL qualify the accepted byte as the final byte of the program.
REQ-008 ld_ready  output  1  SHALL indicate that the block accepts a byte this cycle.
REQ-009 ld_start  input  1  SHALL be a single-cycle request to reload the memory while running.
REQ-010 cpu_addr  input  32  SHALL be the CPU fetch word address.
REQ-011 cpu_instr  output  32  SHALL be the instruction returned to the CPU.
REQ-012 cpu_stall  output  1  SHALL hold the CPU while memory is being loaded.
REQ-013 addr_err  output  1  SHALL flag a fetch outside the memory range.
REQ-014 mem_addr  output  ADDR_W  SHALL be the memory word address.
REQ-015 mem_we  output  1  SHALL be the memory write strobe.
REQ-016 mem_wdata  output  32  SHALL be the memory write data.
REQ-017 mem_rdata  input  32  SHALL be the memory combinational read data.
REQ-018 word_count  output  ADDR_W+1  SHALL report the number of words written since the last load began.

Function
REQ-019 The FSM SHALL have three states: LOAD (assemble bytes), WRITE (one-cycle memory write) and RUN (CPU owns memory).
REQ-020 LOAD: ld_ready=1, cpu_stall=1; a byte is accepted when ld_valid and ld_ready are both 1, and it shifts into a 32-bit assembly register from the LSB end, so the first byte of a word lands in bits 31:24.
REQ-021 On the 4th accepted byte, or on any accepted byte with ld_last=1, the FSM SHALL enter WRITE on the next edge; a partial word SHALL be left-justified with zero padding in the low bytes.
REQ-022 WRITE: mem_we=1 for exactly one cycle, mem_addr=word_count[ADDR_W-1:0], mem_wdata=assembled word, ld_ready=0; word_count increments and the byte counter clears at the end of the cycle.
REQ-023 The WRITE state SHALL exit to RUN if the word carried ld_last or word_count reaches DEPTH after the increment; otherwise it exits to LOAD.
REQ-024 RUN: ld_ready=0, cpu_stall=0, mem_we=0, mem_addr=cpu_addr[ADDR_W-1:0], cpu_instr=mem_rdata (combinational, zero latency).
REQ-025 In RUN, if cpu_addr[31:ADDR_W] is nonzero, the block SHALL drive cpu_instr=32'h0 (nop) and addr_err=1 in the same cycle; addr_err is otherwise 0.
REQ-026 In LOAD and WRITE, cpu_instr SHALL be 32'h0 and addr_err SHALL be 0.
REQ-027 The ld_start input SHALL be acted on only in RUN; it moves the FSM to LOAD and clears word_count and the byte counter on the next edge.
REQ-028 The block SHALL ignore ld_start in LOAD and WRITE, and SHALL ignore ld_valid outside LOAD.
REQ-029 ld_last with zero bytes pending cannot occur, because ld_last always accompanies an accepted byte.
REQ-030 A load of exactly DEPTH words SHALL end in RUN even when ld_last is never asserted; word_count SHALL then equal DEPTH and SHALL NOT wrap.
REQ-031 Words not written during a load SHALL keep their previous memory contents; the block SHALL NOT clear the memory.

Reset
REQ-032 Asserting reset SHALL immediately force state=LOAD, word_count=0, byte counter=0, assembly register=0, mem_we=0, ld_ready=1, cpu_stall=1, cpu_instr=0 and addr_err=0.
REQ-033 Reset asserted during WRITE SHALL suppress that write (mem_we=0 at once), and loading SHALL restart at word 0.

Verification
REQ-034 Send bytes 20,00,00,01 then 08,00,00,01 with ld_last on the final byte -> two one-cycle writes: word 0 = 32'h20000001, then word 1 = 32'h08000001; then RUN, cpu_stall=0, word_count=2.
REQ-035 Send 3 bytes AA,BB,CC with ld_last on the 3rd -> word 0 = 32'hAABBCC00; then RUN.
REQ-036 Send 1024 bytes with no ld_last -> 256 writes to addresses 0..255, RUN entered after the last write, word_count=256, and a 1025th byte is not accepted (ld_ready=0).
REQ-037 In RUN with cpu_addr=5 -> mem_addr=5 and cpu_instr=mem_rdata; with cpu_addr=32'h100 -> cpu_instr=0 and addr_err=1 in the same cycle.
REQ-038 Pulse ld_start in RUN, send 4 bytes, and pulse ld_start again during LOAD -> the second ld_start is ignored, the write goes to address 0, and cpu_stall=1 until ld_last.
REQ-039 Assert reset in the WRITE cycle of word 3 -> no write to address 3, word_count=0, and the next 4 bytes write address 0.

Source files
------------

// File: rtl/imem_boot_ctrl_if.sv
// Bundles the loader byte stream, CPU fetch port and instruction-memory port of imem_boot_ctrl.
// Loader handshake: a byte transfers on a rising clk edge where ld_valid && ld_ready; ld_data/ld_last are held while ld_valid waits.
interface imem_boot_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_start;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_instr;
  logic              cpu_stall;
  logic              addr_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [ADDR_W:0]   word_count;
  logic [1:0]        dbg_state;

  modport slave (
    input  ld_valid, ld_data, ld_last, ld_start, cpu_addr, mem_rdata,
    output ld_ready, cpu_instr, cpu_stall, addr_err, mem_addr, mem_we, mem_wdata,
           word_count, dbg_state
  );

  modport master (
    output ld_valid, ld_data, ld_last, ld_start, cpu_addr, mem_rdata,
    input  ld_ready, cpu_instr, cpu_stall, addr_err, mem_addr, mem_we, mem_wdata,
           word_count, dbg_state
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot loader for an instruction memory: packs MSB-first bytes into 32-bit words, writes them,
// then hands the memory to the CPU until a reload is requested.
module imem_boot_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic            clk,
  input logic            reset,
  imem_boot_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WRITE = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     asm_q, asm_d;
  logic [ADDR_W:0] word_cnt_q, word_cnt_d;
  logic            last_q, last_d;
  logic [31:0]     shifted;
  logic [31:0]     justified;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      word_cnt_q <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      word_cnt_q <= word_cnt_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    asm_d          = asm_q;
    word_cnt_d     = word_cnt_q;
    last_d         = last_q;
    bus.ld_ready   = 1'b0;
    bus.cpu_stall  = 1'b1;
    bus.cpu_instr  = 32'h0;
    bus.addr_err   = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = word_cnt_q[ADDR_W-1:0];
    bus.mem_wdata  = asm_q;
    shifted        = {asm_q[23:0], bus.ld_data};
    // A short final word is left-justified so its first byte still sits in bits 31:24.
    case (byte_cnt_q)
      2'd0:    justified = {bus.ld_data, 24'h0};
      2'd1:    justified = {asm_q[7:0], bus.ld_data, 16'h0};
      2'd2:    justified = {asm_q[15:0], bus.ld_data, 8'h0};
      default: justified = shifted;
    endcase

    case (state_q)
      S_LOAD: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          last_d     = bus.ld_last;
          asm_d      = bus.ld_last ? justified : shifted;
          if (bus.ld_last || byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        bus.mem_we = 1'b1;
        word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
        byte_cnt_d = '0;
        asm_d      = '0;
        last_d     = 1'b0;
        state_d    = (last_q || word_cnt_q == LAST_WORD) ? S_RUN : S_LOAD;
      end
      S_RUN: begin
        bus.cpu_stall = 1'b0;
        bus.mem_addr  = bus.cpu_addr[ADDR_W-1:0];
        if (|bus.cpu_addr[31:ADDR_W]) begin
          bus.addr_err = 1'b1;
        end else begin
          bus.cpu_instr = bus.mem_rdata;
        end
        if (bus.ld_start) begin
          state_d    = S_LOAD;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
          last_d     = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign bus.word_count = word_cnt_q;
  assign bus.dbg_state  = state_q;
endmodule
